// File: rtl/dmem_pkg.sv
// Shared definitions for the wait-stated data-memory responder:
// RV32 load/store size codes, FSM states and request legality.
package dmem_pkg;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Unsigned variants only make sense for loads.
    function automatic logic op_legal(input logic we, input logic [2:0] op);
        logic ok;
        case (op)
            MEM_B, MEM_H, MEM_W: ok = 1'b1;
            MEM_BU, MEM_HU:      ok = !we;
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte-lane steering: store strobes and merge, load extraction and
// extension, and alignment check for one 32-bit word.
module dmem_lane_unit
    import dmem_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] old_i,
    output logic [3:0]  strb_o,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [31:0] wrep;
    logic [31:0] sh;

    assign sh = old_i >> {off_i, 3'b000};

    always_comb begin
        strb_o     = 4'b0000;
        wrep       = wdata_i;
        rdata_o    = 32'h0;
        misalign_o = 1'b0;
        case (op_i)
            MEM_B, MEM_BU: begin
                strb_o  = 4'b0001 << off_i;
                wrep    = {4{wdata_i[7:0]}};
                rdata_o = (op_i == MEM_B) ? {{24{sh[7]}}, sh[7:0]}
                                          : {24'h0, sh[7:0]};
            end
            MEM_H, MEM_HU: begin
                strb_o     = off_i[1] ? 4'b1100 : 4'b0011;
                wrep       = {2{wdata_i[15:0]}};
                misalign_o = off_i[0];
                rdata_o    = (op_i == MEM_H) ? {{16{sh[15]}}, sh[15:0]}
                                             : {16'h0, sh[15:0]};
            end
            MEM_W: begin
                strb_o     = 4'b1111;
                misalign_o = (off_i != 2'b00);
                rdata_o    = old_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        wword_o = old_i;
        for (int i = 0; i < 4; i++) begin
            if (strb_o[i]) wword_o[8*i +: 8] = wrep[8*i +: 8];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory target with a programmable wait
// between request acceptance and response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_op_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be within 1..15");
    end

    localparam int          AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] BYTES = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  CNT0  = 4'(LATENCY - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        mem_we;

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic [31:0] old_word;
    logic [3:0]  strb;
    logic [31:0] wword;
    logic [31:0] lrdata;
    logic        misalign;
    logic        acc_err;

    assign idx      = addr_q[AW+1:2];
    assign old_word = mem_q[idx];

    dmem_lane_unit u_lane (
        .op_i       (op_q),
        .off_i      (addr_q[1:0]),
        .wdata_i    (wdata_q),
        .old_i      (old_word),
        .strb_o     (strb),
        .wword_o    (wword),
        .rdata_o    (lrdata),
        .misalign_o (misalign)
    );

    assign acc_err = !op_legal(we_q, op_q) || misalign || (addr_q >= BYTES);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    op_d    = req_op_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    cnt_d   = CNT0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    err_d   = acc_err;
                    rdata_d = (acc_err || we_q) ? 32'h0 : lrdata;
                    mem_we  = we_q && !acc_err;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            op_q    <= MEM_W;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage survives reset; a reset edge also suppresses a pending write.
    always_ff @(posedge clk_i) begin
        if (rst_i && mem_we && (strb != 4'b0000)) begin
            mem_q[idx] <= wword;
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = (state_q == RESP);
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;

endmodule
